// File: rtl/hazard_resolve_if.sv
// Bundle of signals between the hazard detector/pipeline and the hazard
// resolve unit: detector flags and pipeline events in, pipeline controls,
// forwarding selects and performance counters out.
interface hazard_resolve_if #(
   parameter int CNT_W = 16
);
   logic [10:0]      haz;
   logic             stall;
   logic             ex_branch_taken;
   logic             md_start;
   logic             md_done;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_bubble;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [1:0]       fwd_cmp_sel;
   logic [1:0]       fwd_r0_sel;
   logic [1:0]       fwd_st_sel;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline/detector side: drives hazards and events, consumes controls.
   modport master (
      output haz, stall, ex_branch_taken, md_start, md_done,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
      input  fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_st_sel,
      input  stall_cnt, flush_cnt
   );

   // Resolve unit side.
   modport slave (
      input  haz, stall, ex_branch_taken, md_start, md_done,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
      output fwd_a_sel, fwd_b_sel, fwd_cmp_sel, fwd_r0_sel, fwd_st_sel,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_resolve_unit.sv
// Hazard resolve unit: turns decode-stage hazard flags into registered EX
// forwarding selects, and sequences pipeline hold/bubble/flush for taken
// branches, load-use stalls and multi-cycle multiply/divide.
module hazard_resolve_unit #(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic            clk,
   input  logic            rst,
   hazard_resolve_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      MDWAIT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       rem;
   logic [1:0]       rem_nxt;
   logic             stall_inc;
   logic             flush_inc;
   logic [1:0]       a_nxt;
   logic [1:0]       b_nxt;
   logic [1:0]       cmp_nxt;
   logic [1:0]       r0_nxt;
   logic [1:0]       st_nxt;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // State and remaining-bubble register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         rem   <= 2'd0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
      end
   end

   // Next-state logic: branch flush beats multiply/divide beats load-use stall.
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      case (state)
         RUN: begin
            if (bus.ex_branch_taken) begin
               state_nxt = RUN;
            end else if (bus.md_start) begin
               if (!bus.md_done) state_nxt = MDWAIT;
            end else if (bus.stall) begin
               if (STALL_CYCLES > 1) begin
                  rem_nxt   = 2'(STALL_CYCLES - 2);
                  state_nxt = LDSTALL;
               end
            end
         end
         LDSTALL: begin
            if (bus.ex_branch_taken || rem == 2'd0) begin
               rem_nxt   = 2'd0;
               state_nxt = RUN;
            end else begin
               rem_nxt = rem - 2'd1;
            end
         end
         MDWAIT: begin
            if (bus.md_done) state_nxt = RUN;
         end
         default: begin
            rem_nxt   = 2'd0;
            state_nxt = RUN;
         end
      endcase
   end

   // Pipeline control outputs and counter increment strobes.
   always_comb begin
      bus.pc_en       = 1'b1;
      bus.ifid_en     = 1'b1;
      bus.idex_en     = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;
      case (state)
         RUN: begin
            if (bus.ex_branch_taken) begin
               bus.ifid_flush  = 1'b1;
               bus.idex_bubble = 1'b1;
               flush_inc       = 1'b1;
            end else if (bus.md_start) begin
               if (!bus.md_done) begin
                  bus.pc_en   = 1'b0;
                  bus.ifid_en = 1'b0;
                  bus.idex_en = 1'b0;
               end
            end else if (bus.stall) begin
               bus.pc_en       = 1'b0;
               bus.ifid_en     = 1'b0;
               bus.idex_bubble = 1'b1;
               stall_inc       = 1'b1;
            end
         end
         LDSTALL: begin
            if (bus.ex_branch_taken) begin
               bus.ifid_flush  = 1'b1;
               bus.idex_bubble = 1'b1;
               flush_inc       = 1'b1;
            end else begin
               bus.pc_en       = 1'b0;
               bus.ifid_en     = 1'b0;
               bus.idex_bubble = 1'b1;
               stall_inc       = 1'b1;
            end
         end
         MDWAIT: begin
            if (!bus.md_done) begin
               bus.pc_en   = 1'b0;
               bus.ifid_en = 1'b0;
               bus.idex_en = 1'b0;
            end
         end
         default: begin
            bus.pc_en = 1'b1;
         end
      endcase
   end

   // Priority decode of hazard flags into the next forwarding selects.
   always_comb begin
      a_nxt   = bus.haz[1] ? 2'b01 : (bus.haz[0] ? 2'b10 : 2'b00);
      b_nxt   = bus.haz[2] ? 2'b01 : (bus.haz[3] ? 2'b10 : 2'b00);
      cmp_nxt = bus.haz[4] ? 2'b01 : (bus.haz[5] ? 2'b10 : 2'b00);
      r0_nxt  = bus.haz[6] ? 2'b01 : (bus.haz[7] ? 2'b10 : 2'b00);
      st_nxt  = bus.haz[10] ? 2'b01 :
                (bus.haz[8] ? 2'b11 : (bus.haz[9] ? 2'b10 : 2'b00));
   end

   // ID/EX select registers: cleared by a bubble, frozen while ID/EX holds.
   always_ff @(posedge clk) begin
      if (rst || bus.idex_bubble) begin
         bus.fwd_a_sel   <= 2'b00;
         bus.fwd_b_sel   <= 2'b00;
         bus.fwd_cmp_sel <= 2'b00;
         bus.fwd_r0_sel  <= 2'b00;
         bus.fwd_st_sel  <= 2'b00;
      end else if (bus.idex_en) begin
         bus.fwd_a_sel   <= a_nxt;
         bus.fwd_b_sel   <= b_nxt;
         bus.fwd_cmp_sel <= cmp_nxt;
         bus.fwd_r0_sel  <= r0_nxt;
         bus.fwd_st_sel  <= st_nxt;
      end
   end

   // Saturating bubble and flush counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_inc && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_inc && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_resolve_unit.sv
// Directed bench for hazard_resolve_unit with two bubbles per load-use stall
// and 4-bit counters so saturation is reachable quickly.
module tb_hazard_resolve_unit;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   int   failed;

   hazard_resolve_if #(.CNT_W(4)) bus ();

   hazard_resolve_unit #(
      .STALL_CYCLES(2),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's inputs on the falling edge, then let logic settle.
   task automatic applyStimulus(input logic r, input logic [10:0] h,
                                input logic s, input logic b,
                                input logic ms, input logic md);
      @(negedge clk);
      rst                 = r;
      bus.haz             = h;
      bus.stall           = s;
      bus.ex_branch_taken = b;
      bus.md_start        = ms;
      bus.md_done         = md;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Directed sequence of steps.
   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      rst                 = 1'b1;
      bus.haz             = '0;
      bus.stall           = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.md_start        = 1'b0;
      bus.md_done         = 1'b0;

      applyStimulus(1, 11'h000, 0, 0, 0, 0);
      applyStimulus(1, 11'h000, 0, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("rst_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("rst_ifid_en", 16'(bus.ifid_en), 16'd1);
      checkOutput("rst_idex_en", 16'(bus.idex_en), 16'd1);
      checkOutput("rst_flush", 16'(bus.ifid_flush), 16'd0);
      checkOutput("rst_bubble", 16'(bus.idex_bubble), 16'd0);
      checkOutput("rst_a", 16'(bus.fwd_a_sel), 16'd0);
      checkOutput("rst_st", 16'(bus.fwd_st_sel), 16'd0);
      checkOutput("rst_stall_cnt", 16'(bus.stall_cnt), 16'd0);
      checkOutput("rst_flush_cnt", 16'(bus.flush_cnt), 16'd0);

      $display("[TB] select mapping");
      applyStimulus(0, 11'h002, 0, 0, 0, 0);
      applyStimulus(0, 11'h003, 0, 0, 0, 0);
      checkOutput("a_h002", 16'(bus.fwd_a_sel), 16'd1);
      applyStimulus(0, 11'h001, 0, 0, 0, 0);
      checkOutput("a_h003", 16'(bus.fwd_a_sel), 16'd1);
      applyStimulus(0, 11'h500, 0, 0, 0, 0);
      checkOutput("a_h001", 16'(bus.fwd_a_sel), 16'd2);
      applyStimulus(0, 11'h100, 0, 0, 0, 0);
      checkOutput("st_h500", 16'(bus.fwd_st_sel), 16'd1);
      checkOutput("a_h500", 16'(bus.fwd_a_sel), 16'd0);
      applyStimulus(0, 11'h00C, 0, 0, 0, 0);
      checkOutput("st_h100", 16'(bus.fwd_st_sel), 16'd3);
      applyStimulus(0, 11'h0A0, 0, 0, 0, 0);
      checkOutput("b_h00c", 16'(bus.fwd_b_sel), 16'd1);
      applyStimulus(0, 11'h050, 0, 0, 0, 0);
      checkOutput("cmp_h0a0", 16'(bus.fwd_cmp_sel), 16'd2);
      checkOutput("r0_h0a0", 16'(bus.fwd_r0_sel), 16'd2);
      applyStimulus(0, 11'h200, 0, 0, 0, 0);
      checkOutput("cmp_h050", 16'(bus.fwd_cmp_sel), 16'd1);
      checkOutput("r0_h050", 16'(bus.fwd_r0_sel), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("st_h200", 16'(bus.fwd_st_sel), 16'd2);
      checkOutput("b_h200", 16'(bus.fwd_b_sel), 16'd0);

      $display("[TB] branch taken together with stall");
      applyStimulus(0, 11'h002, 1, 1, 0, 0);
      checkOutput("br_flush", 16'(bus.ifid_flush), 16'd1);
      checkOutput("br_bubble", 16'(bus.idex_bubble), 16'd1);
      checkOutput("br_pc_en", 16'(bus.pc_en), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("br_flush_cnt", 16'(bus.flush_cnt), 16'd1);
      checkOutput("br_stall_cnt", 16'(bus.stall_cnt), 16'd0);
      checkOutput("br_run_bubble", 16'(bus.idex_bubble), 16'd0);
      checkOutput("br_run_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("br_a_cleared", 16'(bus.fwd_a_sel), 16'd0);

      $display("[TB] load-use stall");
      applyStimulus(0, 11'h002, 0, 0, 0, 0);
      applyStimulus(0, 11'h001, 1, 0, 0, 0);
      checkOutput("ld1_a_prev", 16'(bus.fwd_a_sel), 16'd1);
      checkOutput("ld1_pc_en", 16'(bus.pc_en), 16'd0);
      checkOutput("ld1_ifid_en", 16'(bus.ifid_en), 16'd0);
      checkOutput("ld1_idex_en", 16'(bus.idex_en), 16'd1);
      checkOutput("ld1_bubble", 16'(bus.idex_bubble), 16'd1);
      applyStimulus(0, 11'h001, 0, 0, 0, 0);
      checkOutput("ld2_pc_en", 16'(bus.pc_en), 16'd0);
      checkOutput("ld2_bubble", 16'(bus.idex_bubble), 16'd1);
      checkOutput("ld2_a", 16'(bus.fwd_a_sel), 16'd0);
      checkOutput("ld2_stall_cnt", 16'(bus.stall_cnt), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("ld3_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("ld3_bubble", 16'(bus.idex_bubble), 16'd0);
      checkOutput("ld3_a", 16'(bus.fwd_a_sel), 16'd0);
      checkOutput("ld3_stall_cnt", 16'(bus.stall_cnt), 16'd2);

      $display("[TB] branch during second bubble");
      applyStimulus(0, 11'h000, 1, 0, 0, 0);
      checkOutput("lb1_bubble", 16'(bus.idex_bubble), 16'd1);
      applyStimulus(0, 11'h000, 0, 1, 0, 0);
      checkOutput("lb2_flush", 16'(bus.ifid_flush), 16'd1);
      checkOutput("lb2_bubble", 16'(bus.idex_bubble), 16'd1);
      checkOutput("lb2_pc_en", 16'(bus.pc_en), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("lb3_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("lb3_bubble", 16'(bus.idex_bubble), 16'd0);
      checkOutput("lb3_stall_cnt", 16'(bus.stall_cnt), 16'd3);
      checkOutput("lb3_flush_cnt", 16'(bus.flush_cnt), 16'd2);
      applyStimulus(0, 11'h000, 1, 0, 0, 0);
      checkOutput("fresh1_bubble", 16'(bus.idex_bubble), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("fresh2_bubble", 16'(bus.idex_bubble), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("fresh3_bubble", 16'(bus.idex_bubble), 16'd0);
      checkOutput("fresh3_stall_cnt", 16'(bus.stall_cnt), 16'd5);

      $display("[TB] multiply/divide freeze");
      applyStimulus(0, 11'h001, 0, 0, 0, 0);
      applyStimulus(0, 11'h002, 0, 0, 1, 0);
      checkOutput("md0_pc_en", 16'(bus.pc_en), 16'd0);
      checkOutput("md0_ifid_en", 16'(bus.ifid_en), 16'd0);
      checkOutput("md0_idex_en", 16'(bus.idex_en), 16'd0);
      checkOutput("md0_a", 16'(bus.fwd_a_sel), 16'd2);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 11'h002, 0, 0, 0, 0);
         checkOutput("mdw_pc_en", 16'(bus.pc_en), 16'd0);
         checkOutput("mdw_idex_en", 16'(bus.idex_en), 16'd0);
         checkOutput("mdw_a", 16'(bus.fwd_a_sel), 16'd2);
      end
      applyStimulus(0, 11'h002, 0, 0, 0, 1);
      checkOutput("md4_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("md4_ifid_en", 16'(bus.ifid_en), 16'd1);
      checkOutput("md4_idex_en", 16'(bus.idex_en), 16'd1);
      checkOutput("md4_a", 16'(bus.fwd_a_sel), 16'd2);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("md5_a", 16'(bus.fwd_a_sel), 16'd1);
      checkOutput("md5_pc_en", 16'(bus.pc_en), 16'd1);

      $display("[TB] reset during multiply/divide wait");
      applyStimulus(0, 11'h002, 0, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 1, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("mr1_pc_en", 16'(bus.pc_en), 16'd0);
      applyStimulus(1, 11'h000, 0, 0, 0, 0);
      checkOutput("mr2_a_held", 16'(bus.fwd_a_sel), 16'd1);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("mr3_pc_en", 16'(bus.pc_en), 16'd1);
      checkOutput("mr3_ifid_en", 16'(bus.ifid_en), 16'd1);
      checkOutput("mr3_idex_en", 16'(bus.idex_en), 16'd1);
      checkOutput("mr3_stall_cnt", 16'(bus.stall_cnt), 16'd0);
      checkOutput("mr3_flush_cnt", 16'(bus.flush_cnt), 16'd0);
      checkOutput("mr3_a", 16'(bus.fwd_a_sel), 16'd0);

      $display("[TB] stall counter saturation");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 11'h000, 1, 0, 0, 0);
         applyStimulus(0, 11'h000, 0, 0, 0, 0);
      end
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("sat_14", 16'(bus.stall_cnt), 16'd14);
      applyStimulus(0, 11'h000, 1, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("sat_15", 16'(bus.stall_cnt), 16'd15);
      applyStimulus(0, 11'h000, 1, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      applyStimulus(0, 11'h000, 0, 0, 0, 0);
      checkOutput("sat_hold", 16'(bus.stall_cnt), 16'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
